// File: rtl/mmi_mod_clkp_pkg.sv
// Shared constants for the MMIO timebase prescaler: default clock and tick
// rates plus the accumulator width used by every rate channel.
package mmi_mod_clkp_pkg;

   localparam int CLK_HZ_DEFAULT   = 100000000;
   localparam int RATE_1M_DEFAULT  = 1000000;
   localparam int RATE_64K_DEFAULT = 65536;
   localparam int RATE_1K_DEFAULT  = 1000;
   localparam int RATE_256_DEFAULT = 256;

   localparam int ACC_W = 32;

endpackage

// File: rtl/clkp_rate_gen.sv
// One fractional (DDA) tick channel: adds RATE every clock and emits a
// one-cycle tick each time the running sum crosses CLK_HZ.
module clkp_rate_gen
   import mmi_mod_clkp_pkg::*;
#(
   parameter int CLK_HZ = CLK_HZ_DEFAULT,
   parameter int RATE   = RATE_1M_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int SUM_W = ACC_W + 1;
   localparam logic [SUM_W-1:0] RATE_S = SUM_W'(RATE);
   localparam logic [SUM_W-1:0] CLK_S  = SUM_W'(CLK_HZ);

   if (!(RATE > 0 && RATE < CLK_HZ)) begin : g_bad_rate
      $error("clkp_rate_gen: RATE %0d must satisfy 0 < RATE < CLK_HZ %0d", RATE, CLK_HZ);
   end

   logic [ACC_W-1:0] acc;
   logic [SUM_W-1:0] sum;
   logic             wrap;
   logic [ACC_W-1:0] accNext;

   // The extra sum bit keeps acc + RATE exact; the remainder always fits ACC_W
   // because acc stays below CLK_HZ.
   assign sum     = {1'b0, acc} + RATE_S;
   assign wrap    = (sum >= CLK_S);
   assign accNext = wrap ? ACC_W'(sum - CLK_S) : ACC_W'(sum);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc  <= '0;
         tick <= 1'b0;
      end else begin
         acc  <= accNext;
         tick <= wrap;
      end
   end

endmodule

// File: rtl/mmi_mod_clkp.sv
// Free-running timebase prescaler: four independent DDA channels producing
// 1 MHz, 64 kHz, 1 kHz and 256 Hz single-cycle tick strobes.
module mmi_mod_clkp
   import mmi_mod_clkp_pkg::*;
#(
   parameter int CLK_HZ   = CLK_HZ_DEFAULT,
   parameter int RATE_1M  = RATE_1M_DEFAULT,
   parameter int RATE_64K = RATE_64K_DEFAULT,
   parameter int RATE_1K  = RATE_1K_DEFAULT,
   parameter int RATE_256 = RATE_256_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   output logic timer1MHz,
   output logic timer64kHz,
   output logic timer1kHz,
   output logic timer256Hz
);

   if (CLK_HZ < 2) begin : g_bad_clk
      $error("mmi_mod_clkp: CLK_HZ %0d out of range", CLK_HZ);
   end

   clkp_rate_gen #(.CLK_HZ(CLK_HZ), .RATE(RATE_1M)) u_gen1M (
      .clock(clock), .reset(reset), .tick(timer1MHz)
   );

   clkp_rate_gen #(.CLK_HZ(CLK_HZ), .RATE(RATE_64K)) u_gen64k (
      .clock(clock), .reset(reset), .tick(timer64kHz)
   );

   clkp_rate_gen #(.CLK_HZ(CLK_HZ), .RATE(RATE_1K)) u_gen1k (
      .clock(clock), .reset(reset), .tick(timer1kHz)
   );

   clkp_rate_gen #(.CLK_HZ(CLK_HZ), .RATE(RATE_256)) u_gen256 (
      .clock(clock), .reset(reset), .tick(timer256Hz)
   );

endmodule

// File: tb/tb_mmi_mod_clkp.sv
// Bench for mmi_mod_clkp at a scaled-down clock so full rate windows fit in a
// short run; expected ticks come from strobe-count arithmetic floor(n*R/CLK).
module tb_mmi_mod_clkp;

   localparam int CLK_HZ   = 20000;
   localparam int RATE_1M  = 1000;   // period 20
   localparam int RATE_64K = 1311;   // non-integer, intervals 15 or 16
   localparam int RATE_1K  = 100;    // period 200
   localparam int RATE_256 = 8;      // period 2500, a multiple of 20

   logic clock;
   logic reset;
   logic timer1MHz, timer64kHz, timer1kHz, timer256Hz;
   logic [3:0] ticks;
   int rates [4];

   int checks   = 0;
   int failures = 0;

   mmi_mod_clkp #(
      .CLK_HZ(CLK_HZ), .RATE_1M(RATE_1M), .RATE_64K(RATE_64K),
      .RATE_1K(RATE_1K), .RATE_256(RATE_256)
   ) dut (
      .clock(clock), .reset(reset),
      .timer1MHz(timer1MHz), .timer64kHz(timer64kHz),
      .timer1kHz(timer1kHz), .timer256Hz(timer256Hz)
   );

   assign ticks = {timer256Hz, timer1kHz, timer64kHz, timer1MHz};

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: a channel has produced floor(n*R/CLK) strobes after n edges,
   // so it strobes on edge n exactly when that count steps.
   function automatic logic exp_tick(input int n, input int r);
      longint a, b;
      if (n <= 0) return 1'b0;
      a = (longint'(n) * r) / CLK_HZ;
      b = (longint'(n - 1) * r) / CLK_HZ;
      return (a != b);
   endfunction

   // Advance one rising edge and settle on the following falling edge.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (ticks !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold cycle=%0d got=%b exp=0000", i, ticks);
         end
      end
   endtask

   // Full CLK_HZ window after release: per-cycle model check, exact counts,
   // first-strobe latency, interval bounds and 256/1M coincidence.
   task automatic test_full_window();
      int cnt [4];
      int first [4];
      int last [4];
      int badIv [4];
      int coincideBad;
      logic e;
      coincideBad = 0;
      for (int c = 0; c < 4; c++) begin
         cnt[c] = 0; first[c] = -1; last[c] = 0; badIv[c] = 0;
      end
      release_reset();
      for (int n = 1; n <= CLK_HZ; n++) begin
         step();
         for (int c = 0; c < 4; c++) begin
            e = exp_tick(n, rates[c]);
            checks++;
            if (ticks[c] !== e) begin
               failures++;
               if (failures < 40)
                  $display("FAIL window_tick ch=%0d edge=%0d got=%b exp=%b", c, n, ticks[c], e);
            end
            if (ticks[c] === 1'b1) begin
               if (first[c] < 0) first[c] = n;
               else if ((n - last[c]) != CLK_HZ / rates[c] &&
                        (n - last[c]) != (CLK_HZ + rates[c] - 1) / rates[c])
                  badIv[c]++;
               last[c] = n;
               cnt[c]++;
            end
         end
         if (timer256Hz === 1'b1 && timer1MHz !== 1'b1) coincideBad++;
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (cnt[c] != rates[c]) begin
            failures++;
            $display("FAIL window_count ch=%0d got=%0d exp=%0d", c, cnt[c], rates[c]);
         end
         checks++;
         if (first[c] != (CLK_HZ + rates[c] - 1) / rates[c]) begin
            failures++;
            $display("FAIL first_strobe ch=%0d got=%0d exp=%0d", c, first[c],
                     (CLK_HZ + rates[c] - 1) / rates[c]);
         end
         checks++;
         if (badIv[c] != 0) begin
            failures++;
            $display("FAIL interval ch=%0d bad_intervals=%0d exp=0", c, badIv[c]);
         end
      end
      checks++;
      if (coincideBad != 0) begin
         failures++;
         $display("FAIL coincide_256_1M got=%0d exp=0", coincideBad);
      end
   endtask

   // Reset asserted between edges while timer1MHz is high, then a fresh phase.
   task automatic test_mid_reset();
      int k;
      int firstAfter;
      logic e;
      reset = 1'b0;
      step();
      release_reset();
      k = 20 * $urandom_range(2, 12);
      for (int n = 1; n <= k; n++) step();
      checks++;
      if (timer1MHz !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_high edge=%0d got=%b exp=1", k, timer1MHz);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (ticks !== 4'b0000) begin
         failures++;
         $display("FAIL async_reset got=%b exp=0000", ticks);
      end
      step();
      release_reset();
      firstAfter = -1;
      for (int n = 1; n <= 60; n++) begin
         step();
         e = exp_tick(n, RATE_1M);
         checks++;
         if (timer1MHz !== e) begin
            failures++;
            $display("FAIL mid_reset_tick edge=%0d got=%b exp=%b", n, timer1MHz, e);
         end
         if (timer1MHz === 1'b1 && firstAfter < 0) firstAfter = n;
      end
      checks++;
      if (firstAfter != CLK_HZ / RATE_1M) begin
         failures++;
         $display("FAIL mid_reset_first got=%0d exp=%0d", firstAfter, CLK_HZ / RATE_1M);
      end
   endtask

   // Random-length runs each starting from reset, all channels vs model.
   task automatic test_random_runs();
      int len;
      logic e;
      for (int it = 0; it < 4; it++) begin
         reset = 1'b0;
         step();
         release_reset();
         len = $urandom_range(100, 3000);
         for (int n = 1; n <= len; n++) begin
            step();
            for (int c = 0; c < 4; c++) begin
               e = exp_tick(n, rates[c]);
               checks++;
               if (ticks[c] !== e) begin
                  failures++;
                  if (failures < 40)
                     $display("FAIL random_tick run=%0d ch=%0d edge=%0d got=%b exp=%b",
                              it, c, n, ticks[c], e);
               end
            end
         end
      end
   endtask

   initial begin
      rates[0] = RATE_1M;
      rates[1] = RATE_64K;
      rates[2] = RATE_1K;
      rates[3] = RATE_256;
      reset = 1'b0;
      test_reset();
      test_full_window();
      test_mid_reset();
      test_random_runs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
